// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t    : transaction FSM states
//   MW_*           : func3 memory-width encodings
//   access_illegal : alignment / encoding legality check for one request
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;

  // Unsigned widths only make sense for loads; reserved encodings are always illegal.
  function automatic logic access_illegal(input logic       wen,
                                          input logic [2:0] width,
                                          input logic [1:0] off);
    logic ill;
    ill = 1'b1;
    case (width)
      MW_B:    ill = 1'b0;
      MW_H:    ill = off[0];
      MW_W:    ill = (off != 2'b00);
      MW_BU:   ill = wen;
      MW_HU:   ill = wen | off[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the LSU (master) and memory (slave).
//   bus_req_valid/bus_req_ready : request handshake
//   bus_addr, bus_wen           : word-aligned address, write enable
//   bus_wdata, bus_wstrb        : lane-replicated store data, byte strobes
//   bus_resp_valid, bus_rdata   : response / write ack, raw read word
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    bus_req_valid;
  logic                    bus_req_ready;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic                    bus_wen;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic [DATA_WIDTH/8-1:0] bus_wstrb;
  logic                    bus_resp_valid;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );

endinterface

// File: rtl/lsu_load_ext.sv
// Combinational load extractor: selects the byte/half/word lane of a raw
// 32-bit read word and sign- or zero-extends it.
//   raw   : raw bus word
//   off   : byte offset within the word (addr[1:0])
//   width : func3 width encoding
//   ext   : extended result (0 for reserved encodings)
module load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  width,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    ext = '0;
    case (width)
      MW_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      MW_BU:   ext = {24'd0, byte_sel};
      MW_H:    ext = {{16{half_sel[15]}}, half_sel};
      MW_HU:   ext = {16'd0, half_sel};
      MW_W:    ext = raw;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit. Accepts one decoded memory operation at a time, runs a
// valid/ready transaction on the data bus and returns extended load data
// with a one-cycle resp_valid pulse. Illegal/misaligned accesses respond
// immediately with misaligned=1 and never touch the bus.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake from the core
//   mem_wen, mem_width    : store flag, func3 width
//   addr, wdata           : byte address, store data (rs2)
//   resp_valid            : one-cycle completion pulse
//   rdata, misaligned     : result data (0 for stores), illegal-access flag
//   bus                   : data-bus master port
// Only DATA_WIDTH = 32 is supported.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_wen,
  input  logic [2:0]            mem_width,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  lsu_if.master                 bus
);

  lsu_state_t state, state_d;

  logic                  accept;
  logic                  illegal;
  logic [1:0]            off_q;
  logic [2:0]            width_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [3:0]            strb_lane;
  logic [31:0]           load_data;

  assign accept  = (state == IDLE) && req_valid;
  assign illegal = access_illegal(mem_wen, mem_width, addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d           = state;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    bus.bus_req_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = illegal ? RESP : REQ;
      end
      REQ: begin
        bus.bus_req_valid = 1'b1;
        if (bus.bus_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.bus_resp_valid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Store lanes are computed from the live request so the bus fields can be
  // registered at acceptance and stay stable through REQ. Only legal
  // accesses reach the bus, so width[1:0] = 2'b10 here is always a word.
  always_comb begin
    wdata_lane = wdata;
    strb_lane  = '0;
    if (mem_wen) begin
      case (mem_width[1:0])
        2'b00: begin
          wdata_lane = {4{wdata[7:0]}};
          strb_lane  = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          wdata_lane = {2{wdata[15:0]}};
          strb_lane  = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_lane = wdata;
          strb_lane  = 4'b1111;
        end
      endcase
    end
  end

  load_ext u_load_ext (
    .raw   (bus.bus_rdata),
    .off   (off_q),
    .width (width_q),
    .ext   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q         <= '0;
      width_q       <= '0;
      wen_q         <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wen   <= 1'b0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
      rdata         <= '0;
      misaligned    <= 1'b0;
    end else begin
      if (accept) begin
        off_q   <= addr[1:0];
        width_q <= mem_width;
        wen_q   <= mem_wen;
        if (illegal) begin
          rdata      <= '0;
          misaligned <= 1'b1;
        end else begin
          bus.bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
          bus.bus_wen   <= mem_wen;
          bus.bus_wdata <= wdata_lane;
          bus.bus_wstrb <= strb_lane;
        end
      end
      if ((state == WAIT) && bus.bus_resp_valid) begin
        rdata      <= wen_q ? '0 : load_data;
        misaligned <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit: the stage directly downstream of instruction decode and the ALU.
- Takes one decoded memory operation at a time: address from the ALU result, store data from rs2, and `mem_width`/`mem_wen`/`valid` from decode.
- Runs a valid/ready transaction on the data bus, then returns load data (sign- or zero-extended) to write-back.
- Holds the core stalled until its one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of the address bus.
- DATA_WIDTH, 32, width of the data bus. Only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  memory operation presented (decode valid qualified by the core)
- req_ready  out  1  LSU idle and able to accept
- mem_wen  in  1  1 = store, 0 = load
- mem_width  in  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; 0 for stores
- misaligned  out  1  valid only with resp_valid; access was misaligned or illegal
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- bus_wen  out  1  write request
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte strobes; 0000 for loads
- bus_resp_valid  in  1  bus response / write acknowledge
- bus_rdata  in  32  raw read word

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - State goes to IDLE.
  - Outputs reset to: `resp_valid`=0, `misaligned`=0, `rdata`=0, `bus_req_valid`=0, `bus_wen`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wstrb`=0.
  - Reset mid-transaction aborts the transaction. A late `bus_resp_valid` that arrives while in IDLE is ignored.
- IDLE:
  - `req_ready`=1; it is 0 in every other state.
  - On `req_valid`, latch addr, width, wen and wdata.
  - If the access is illegal, go to RESP with `misaligned`=1 and issue no bus request. Illegal means any of:
    - H/HU/SH with addr[0]=1;
    - W/SW with addr[1:0]≠0;
    - width 011, 110 or 111;
    - a store with width 100 or 101.
  - Otherwise go to REQ.
- REQ:
  - `bus_req_valid`=1. `bus_addr`, `bus_wen`, `bus_wdata` and `bus_wstrb` stay stable until the handshake.
  - When `bus_req_ready`=1, go to WAIT.
- WAIT:
  - `bus_req_valid`=0.
  - When `bus_resp_valid`=1, capture the extended data and go to RESP.
  - A response is never expected in the same cycle as request acceptance. One arriving in REQ is ignored.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - `rdata`, `misaligned` hold until the next RESP.
- Latency: with a zero-wait bus, `resp_valid` rises 3 cycles after acceptance (accept→REQ→WAIT→RESP). An illegal access responds 1 cycle after acceptance.
- Store lanes (off = addr[1:0]):
  - SB: `bus_wdata`={4{wdata[7:0]}}, `bus_wstrb`=0001<<off.
  - SH: `bus_wdata`={2{wdata[15:0]}}, `bus_wstrb`=0011<<(2·addr[1]).
  - SW: `bus_wdata`=wdata, `bus_wstrb`=1111.
- Load extraction:
  - B/BU: byte = bus_rdata[8·off+7 : 8·off], sign- or zero-extended.
  - H/HU: half = bus_rdata[16·addr[1]+15 : 16·addr[1]], sign- or zero-extended.
  - W: the whole word.
  - A store response sets `rdata`=0.
- `req_valid` while not IDLE is not accepted; the requester must hold it until `req_ready`.

Decomposition:
- Shared header (common.vh):
  - `MemWidth` constants: MW_B=000, MW_H=001, MW_W=010, MW_BU=100, MW_HU=101.
  - `LsuState` enum: IDLE, REQ, WAIT, RESP.
- One combinational sub-module, `load_ext`, with inputs (raw word, offset, width) and output the extended data. It is reused later for the MMIO path.
- Store-lane and strobe logic stay inline.

Test Plan:
- LW at addr 0x80000004 with `bus_rdata`=0xDEADBEEF, bus ready immediately → `bus_addr`=0x80000004, `bus_wstrb`=0000; `resp_valid` 3 cycles after accept; `rdata`=0xDEADBEEF.
- LB/LBU at addr 0x80000003 with `bus_rdata`=0x80FF1234 → LB gives `rdata`=0xFFFFFF80; LBU gives `rdata`=0x00000080. `bus_addr`=0x80000000 in both cases.
- SB at addr 0x80000002 with `wdata`=0x000000AB → `bus_wdata`=0xABABABAB, `bus_wstrb`=0100, `bus_wen`=1; `rdata`=0 at RESP.
- SH at addr 0x80000001 → no `bus_req_valid` ever; `resp_valid` and `misaligned`=1 one cycle after accept.
- LW with `bus_req_ready` low for 4 cycles and response 5 cycles after acceptance → request fields stable throughout, exactly one `resp_valid` pulse.
- Assert `rst` in WAIT, then pulse `bus_resp_valid` after release → IDLE immediately, all outputs 0, no `resp_valid` generated.
